// File: rtl/dmx16_32bits_reg_if.sv
// Bus bundle for the 1-to-16 registered demux: write handshake, lane acks/flush and lane-bank view.
interface dmx16_32bits_reg_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned LANES = 16;

    logic                     i_valid;
    logic                     o_ready;
    logic [WIDTH-1:0]         i_data;
    logic [3:0]               i_sel;
    logic                     i_auto;
    logic [LANES-1:0]         i_ack;
    logic                     i_clr;
    logic [LANES*WIDTH-1:0]   o_lane_data;
    logic [LANES-1:0]         o_lane_vld;
    logic [3:0]               o_ptr;
    logic [4:0]               o_cnt;
    logic                     o_full;

    modport master (
        output i_valid, i_data, i_sel, i_auto, i_ack, i_clr,
        input  o_ready, o_lane_data, o_lane_vld, o_ptr, o_cnt, o_full
    );

    modport slave (
        input  i_valid, i_data, i_sel, i_auto, i_ack, i_clr,
        output o_ready, o_lane_data, o_lane_vld, o_ptr, o_cnt, o_full
    );
endinterface

// File: rtl/dmx16_32bits_reg.sv
// Registered 1-to-16 demux for data words: steers each accepted word into a lane register
// selected explicitly or by an auto-incrementing pointer, with per-lane valid/ack tracking.
module dmx16_32bits_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    dmx16_32bits_reg_if.slave bus
);
    localparam int unsigned LANES = 16;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 5;

    logic [LANES-1:0][WIDTH-1:0] lane_q;
    logic [LANES-1:0]            vld_q;
    logic [SEL_W-1:0]            ptr_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        full_q;

    logic [SEL_W-1:0]            tgt_c;
    logic                        ready_c;
    logic                        wr_c;
    logic [LANES-1:0]            wr_mask_c;
    logic [LANES-1:0]            vld_nxt;
    logic [SEL_W-1:0]            ptr_nxt;
    logic [CNT_W-1:0]            cnt_nxt;
    logic                        full_nxt;

    // Target lane and acceptance: a busy lane frees up in the same cycle it is acked.
    always_comb begin
        tgt_c     = bus.i_auto ? ptr_q : bus.i_sel;
        ready_c   = ~bus.i_clr & (~vld_q[tgt_c] | bus.i_ack[tgt_c]);
        wr_c      = bus.i_valid & ready_c;
        wr_mask_c = wr_c ? (LANES'(1) << tgt_c) : '0;
    end

    // Next flag/pointer/count state; the write mask is OR-ed last so a write beats its own ack.
    always_comb begin
        vld_nxt  = (vld_q & ~bus.i_ack) | wr_mask_c;
        ptr_nxt  = ptr_q;
        if (wr_c && bus.i_auto) begin
            ptr_nxt = ptr_q + SEL_W'(1);
        end
        if (bus.i_clr) begin
            vld_nxt = '0;
            ptr_nxt = '0;
        end
        cnt_nxt = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            cnt_nxt = cnt_nxt + CNT_W'(vld_nxt[k]);
        end
        full_nxt = &vld_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            vld_q  <= vld_nxt;
            ptr_q  <= ptr_nxt;
            cnt_q  <= cnt_nxt;
            full_q <= full_nxt;
        end
    end

    // Lane storage survives acks and flushes; only a reset or a new write changes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
        end else if (wr_c) begin
            lane_q[tgt_c] <= bus.i_data;
        end
    end

    assign bus.o_ready     = ready_c;
    assign bus.o_lane_data = lane_q;
    assign bus.o_lane_vld  = vld_q;
    assign bus.o_ptr       = ptr_q;
    assign bus.o_cnt       = cnt_q;
    assign bus.o_full      = full_q;
endmodule

// File: tb/tb_dmx16_32bits_reg.sv
// Directed self-checking bench for dmx16_32bits_reg: auto fill, stall/release, explicit writes,
// acks, flush priority and asynchronous reset.
module tb_dmx16_32bits_reg;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    dmx16_32bits_reg_if #(.WIDTH(WIDTH)) bus ();

    dmx16_32bits_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane(input int k);
        return bus.o_lane_data[k*WIDTH +: WIDTH];
    endfunction

    task automatic idle();
        bus.i_valid = 1'b0;
        bus.i_ack   = '0;
        bus.i_clr   = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        idle();
        bus.i_data = '0;
        bus.i_sel  = '0;
        bus.i_auto = 1'b1;
        step();
        step();
        check("rst_vld", 32'(bus.o_lane_vld), 32'h0);
        check("rst_cnt", 32'(bus.o_cnt), 32'h0);
        check("rst_full", 32'(bus.o_full), 32'h0);
        check("rst_ptr", 32'(bus.o_ptr), 32'h0);
        check("rst_lane7", lane(7), 32'h0);
        reset = 1'b0;
        step();

        // 1. auto fill
        bus.i_auto  = 1'b1;
        bus.i_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.i_data = 32'(32'hA0 + k);
            #1;
            check("fill_ready", 32'(bus.o_ready), 32'h1);
            step();
        end
        idle();
        #1;
        for (int k = 0; k < 16; k++) check("fill_lane", lane(k), 32'(32'hA0 + k));
        check("fill_vld", 32'(bus.o_lane_vld), 32'hFFFF);
        check("fill_full", 32'(bus.o_full), 32'h1);
        check("fill_cnt", 32'(bus.o_cnt), 32'd16);
        check("fill_ptr", 32'(bus.o_ptr), 32'h0);
        check("fill_ready0", 32'(bus.o_ready), 32'h0);

        // 2. stall released by ack on the target lane
        bus.i_valid = 1'b1;
        bus.i_data  = 32'hBEEF;
        bus.i_ack   = 16'h0001;
        #1;
        check("rel_ready", 32'(bus.o_ready), 32'h1);
        step();
        idle();
        #1;
        check("rel_lane0", lane(0), 32'hBEEF);
        check("rel_vld", 32'(bus.o_lane_vld), 32'hFFFF);
        check("rel_cnt", 32'(bus.o_cnt), 32'd16);
        check("rel_ptr", 32'(bus.o_ptr), 32'h1);

        // 4. multi-ack, no write
        bus.i_ack = 16'h00F0;
        step();
        idle();
        #1;
        check("mack_vld", 32'(bus.o_lane_vld), 32'hFF0F);
        check("mack_cnt", 32'(bus.o_cnt), 32'd12);
        check("mack_full", 32'(bus.o_full), 32'h0);
        check("mack_lane4", lane(4), 32'hA4);
        check("mack_lane0", lane(0), 32'hBEEF);

        // 5. clear beats write and ack
        bus.i_clr   = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'hDEAD;
        bus.i_ack   = 16'hFFFF;
        #1;
        check("clr_ready", 32'(bus.o_ready), 32'h0);
        step();
        idle();
        #1;
        check("clr_vld", 32'(bus.o_lane_vld), 32'h0);
        check("clr_ptr", 32'(bus.o_ptr), 32'h0);
        check("clr_cnt", 32'(bus.o_cnt), 32'h0);
        check("clr_lane1", lane(1), 32'hA1);
        check("clr_lane1b", lane(1) ^ 32'hDEAD, 32'hA1 ^ 32'hDEAD);

        // 3. explicit write into empty bank
        bus.i_auto  = 1'b0;
        bus.i_sel   = 4'd9;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h1234;
        step();
        idle();
        #1;
        check("exp_lane9", lane(9), 32'h1234);
        check("exp_vld", 32'(bus.o_lane_vld), 32'h0200);
        check("exp_cnt", 32'(bus.o_cnt), 32'd1);
        check("exp_ptr", 32'(bus.o_ptr), 32'h0);

        // ack of a clear lane is a no-op
        bus.i_ack = 16'h0001;
        step();
        idle();
        #1;
        check("noop_vld", 32'(bus.o_lane_vld), 32'h0200);
        check("noop_cnt", 32'(bus.o_cnt), 32'd1);

        // stall on occupied explicit lane
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h9999;
        #1;
        check("stall_ready", 32'(bus.o_ready), 32'h0);
        step();
        idle();
        #1;
        check("stall_lane9", lane(9), 32'h1234);

        // write and ack same lane: write wins
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h5678;
        bus.i_ack   = 16'h0200;
        step();
        idle();
        #1;
        check("wa_lane9", lane(9), 32'h5678);
        check("wa_vld", 32'(bus.o_lane_vld), 32'h0200);
        check("wa_cnt", 32'(bus.o_cnt), 32'd1);

        // write one lane while acking another
        bus.i_sel   = 4'd3;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h33;
        bus.i_ack   = 16'h0200;
        step();
        idle();
        #1;
        check("wb_vld", 32'(bus.o_lane_vld), 32'h0008);
        check("wb_lane3", lane(3), 32'h33);
        check("wb_ptr", 32'(bus.o_ptr), 32'h0);

        // 6. async reset mid-write with seven lanes valid
        bus.i_clr = 1'b1;
        step();
        idle();
        bus.i_auto  = 1'b1;
        bus.i_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.i_data = 32'(32'hC0 + k);
            step();
        end
        #1;
        check("pre_cnt", 32'(bus.o_cnt), 32'd7);
        check("pre_ptr", 32'(bus.o_ptr), 32'd7);
        bus.i_data = 32'hC7;
        #1;
        reset = 1'b1;
        #1;
        check("ar_vld", 32'(bus.o_lane_vld), 32'h0);
        check("ar_cnt", 32'(bus.o_cnt), 32'h0);
        check("ar_ptr", 32'(bus.o_ptr), 32'h0);
        check("ar_full", 32'(bus.o_full), 32'h0);
        check("ar_lane0", lane(0), 32'h0);
        check("ar_lane6", lane(6), 32'h0);
        idle();
        step();
        reset = 1'b0;
        step();
        check("post_vld", 32'(bus.o_lane_vld), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
